scope_trig_capture: RTL and testbench

- Downstream consumer of the ADC input stage: takes the registered 8-bit AD9280 samples and runs one oscilloscope acquisition per arm.
- Holds a pre-trigger history, detects a level/edge trigger (normal or auto mode) and fills a DEPTH-sample frame.
- Exposes the frame to the display/readout logic through a synchronous read port.
- Single sys_clk domain; ADC sample rate is qualified by the sample_en strobe.

---
 rtl/scope_trig_capture.sv | 129 ++++++++++++
 tb/tb_scope_trig_capture.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/scope_trig_capture.sv
// Single-shot oscilloscope capture: pre-trigger history, level/edge trigger
// (normal or auto), DEPTH-sample circular frame and a synchronous read port.
module scope_trig_capture #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned AUTO_TIMEOUT = 65536
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              sample_en,
  input  logic [7:0]        sample_data,
  input  logic              arm,
  input  logic [7:0]        trig_level,
  input  logic              trig_falling,
  input  logic              trig_auto,
  input  logic [ADDR_W-1:0] pre_len,
  output logic              busy,
  output logic              done,
  output logic              auto_fired,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] trig_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  localparam int unsigned        DEPTH = 2 ** ADDR_W;
  localparam int unsigned        TO_W  = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0]  LAST  = '1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

  state_t              state, state_nx;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, cnt, post_cnt, post_len;
  logic [TO_W-1:0]     to_cnt;
  logic [7:0]          prev;
  logic                prev_valid;
  logic [7:0]          cfg_level;
  logic                cfg_falling, cfg_auto;
  logic [ADDR_W-1:0]   cfg_pre_len;
  logic                capturing, we, edge_hit, to_hit, trig;

  assign capturing = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  // arm wins over a coincident strobe, so that sample is never written
  assign we        = sample_en && !arm && capturing;
  assign edge_hit  = prev_valid &&
                     (cfg_falling ? (prev > cfg_level && sample_data <= cfg_level)
                                  : (prev < cfg_level && sample_data >= cfg_level));
  assign to_hit    = cfg_auto && (to_cnt == TO_W'(AUTO_TIMEOUT - 1));
  assign trig      = (state == S_ARMED) && we && (edge_hit || to_hit);
  assign post_len  = LAST - cfg_pre_len;
  assign busy      = capturing;
  assign done      = (state == S_DONE);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (arm) begin
      state_nx = (pre_len != '0) ? S_PRE : S_ARMED;
    end else if (we) begin
      case (state)
        S_PRE:   if (cnt + ADDR_W'(1) == cfg_pre_len) state_nx = S_ARMED;
        S_ARMED: if (trig) state_nx = (post_len == '0) ? S_DONE : S_POST;
        S_POST:  if (post_cnt == ADDR_W'(1)) state_nx = S_DONE;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr      <= '0;
      cnt         <= '0;
      post_cnt    <= '0;
      to_cnt      <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      cfg_level   <= '0;
      cfg_falling <= 1'b0;
      cfg_auto    <= 1'b0;
      cfg_pre_len <= '0;
      auto_fired  <= 1'b0;
      start_addr  <= '0;
      trig_addr   <= '0;
    end else if (arm) begin
      cfg_level   <= trig_level;
      cfg_falling <= trig_falling;
      cfg_auto    <= trig_auto;
      cfg_pre_len <= pre_len;
      wr_ptr      <= '0;
      cnt         <= '0;
      to_cnt      <= '0;
      prev_valid  <= 1'b0;
      auto_fired  <= 1'b0;
    end else if (we) begin
      wr_ptr     <= wr_ptr + ADDR_W'(1);
      prev       <= sample_data;
      prev_valid <= 1'b1;
      case (state)
        S_PRE: cnt <= cnt + ADDR_W'(1);
        S_ARMED: begin
          // saturating, so normal mode can sit in ARMED forever
          if (to_cnt != TO_W'(AUTO_TIMEOUT)) to_cnt <= to_cnt + TO_W'(1);
          if (trig) begin
            trig_addr  <= wr_ptr;
            start_addr <= wr_ptr - cfg_pre_len;
            post_cnt   <= post_len;
            auto_fired <= !edge_hit;
          end
        end
        S_POST:  post_cnt <= post_cnt - ADDR_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (we) mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) rd_data <= '0;
    else         rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_scope_trig_capture.sv
// Directed bench for scope_trig_capture (ADDR_W=4, AUTO_TIMEOUT=8).
module tb_scope_trig_capture;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       sample_en;
  logic [7:0] sample_data;
  logic       arm;
  logic [7:0] trig_level;
  logic       trig_falling;
  logic       trig_auto;
  logic [3:0] pre_len;
  logic       busy, done, auto_fired;
  logic [3:0] start_addr, trig_addr;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  scope_trig_capture #(.ADDR_W(4), .AUTO_TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sample_en(sample_en),
    .sample_data(sample_data), .arm(arm), .trig_level(trig_level),
    .trig_falling(trig_falling), .trig_auto(trig_auto), .pre_len(pre_len),
    .busy(busy), .done(done), .auto_fired(auto_fired),
    .start_addr(start_addr), .trig_addr(trig_addr),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] d);
    sample_en   = 1'b1;
    sample_data = d;
    @(negedge sys_clk);
    sample_en   = 1'b0;
  endtask

  task automatic do_arm(input logic [7:0] lvl, input logic fall, input logic au,
                        input logic [3:0] pl, input logic with_sample);
    arm          = 1'b1;
    trig_level   = lvl;
    trig_falling = fall;
    trig_auto    = au;
    pre_len      = pl;
    sample_en    = with_sample;
    sample_data  = 8'd77;
    @(negedge sys_clk);
    arm          = 1'b0;
    sample_en    = 1'b0;
    // scramble config after arm: the DUT must use the latched copy
    trig_level   = ~lvl;
    trig_falling = ~fall;
    trig_auto    = ~au;
    pre_len      = ~pl;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    @(negedge sys_clk);
    chk(tag, rd_data, exp);
  endtask

  task automatic chk_rising_frame(input string tag);
    for (int i = 0; i < 16; i++) rd_chk(tag, 4'((9 + i) % 16), 8'(90 + 10 * i));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1; sample_en = 1'b0; sample_data = '0; arm = 1'b0;
    trig_level = '0; trig_falling = 1'b0; trig_auto = 1'b0; pre_len = '0;
    rd_addr = '0;
    repeat (2) @(negedge sys_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_auto", auto_fired, 0);
    chk("rst_start", start_addr, 0);
    chk("rst_trig", trig_addr, 0);
    chk("rst_rd", rd_data, 0);
    sys_rst = 1'b0;
    put(8'd55); put(8'd55);
    chk("idle_busy", busy, 0);

    // rising, pre_len=4, ramp 0..250 step 10: trigger on 130 at addr 13
    do_arm(8'd128, 1'b0, 1'b0, 4'd4, 1'b0);
    chk("A_busy_arm", busy, 1);
    for (int i = 0; i < 24; i++) put(8'(10 * i));
    chk("A_done_early", done, 0);
    put(8'd240);
    chk("A_done", done, 1);
    chk("A_busy", busy, 0);
    chk("A_trig", trig_addr, 13);
    chk("A_start", start_addr, 9);
    chk("A_auto", auto_fired, 0);
    put(8'd250);
    chk_rising_frame("A_frame");

    // falling, pre_len=2, ramp 200 down: trigger on 100 (prev 110) at addr 10
    do_arm(8'd100, 1'b1, 1'b0, 4'd2, 1'b0);
    for (int i = 0; i < 11; i++) put(8'(200 - 10 * i));
    chk("C_busy", busy, 1);
    chk("C_trig", trig_addr, 10);
    chk("C_start", start_addr, 8);
    chk("C_auto", auto_fired, 0);
    for (int j = 0; j < 12; j++) put(8'(3 * j));
    chk("C_done_early", done, 0);
    put(8'd36);
    chk("C_done", done, 1);
    rd_chk("C_rd8", 4'd8, 8'd120);
    rd_chk("C_rd10", 4'd10, 8'd100);
    rd_chk("C_rd11", 4'd11, 8'd0);
    rd_chk("C_rd7", 4'd7, 8'd36);

    // falling, pre_len=0: level-equal samples never trigger, 150->100 does
    do_arm(8'd100, 1'b1, 1'b0, 4'd0, 1'b0);
    put(8'd100); put(8'd100); put(8'd99); put(8'd150); put(8'd100);
    chk("D_trig", trig_addr, 4);
    chk("D_start", start_addr, 4);
    chk("D_busy", busy, 1);

    // rising, pre_len=0: first sample cannot trigger (no prev)
    do_arm(8'd128, 1'b0, 1'b0, 4'd0, 1'b0);
    put(8'd200); put(8'd50); put(8'd200);
    chk("E_trig", trig_addr, 2);
    chk("E_start", start_addr, 2);

    // rising restart mid-POST, then arm+sample (dropped), then gapped strobe
    do_arm(8'd128, 1'b0, 1'b0, 4'd4, 1'b0);
    for (int i = 0; i < 15; i++) put(8'(10 * i));
    chk("B_busy_post", busy, 1);
    do_arm(8'd128, 1'b0, 1'b0, 4'd4, 1'b1);
    chk("B_done_rearm", done, 0);
    chk("B_busy_rearm", busy, 1);
    for (int i = 0; i < 26; i++) begin
      put(8'(10 * i));
      repeat ((i % 2 == 0) ? 1 : 2) @(negedge sys_clk);
    end
    chk("B_done", done, 1);
    chk("B_trig", trig_addr, 13);
    chk("B_start", start_addr, 9);
    chk_rising_frame("B_frame");

    // auto mode, constant 50: forced trigger on the 8th ARMED sample
    do_arm(8'd128, 1'b0, 1'b1, 4'd4, 1'b0);
    for (int i = 0; i < 11; i++) put(8'd50);
    chk("G_auto_early", auto_fired, 0);
    put(8'd50);
    chk("G_auto", auto_fired, 1);
    chk("G_trig", trig_addr, 11);
    chk("G_start", start_addr, 7);
    for (int i = 0; i < 10; i++) put(8'd50);
    chk("G_done_early", done, 0);
    put(8'd50);
    chk("G_done", done, 1);
    chk("G_auto_held", auto_fired, 1);

    // auto mode, edge on the timeout sample wins
    do_arm(8'd128, 1'b0, 1'b1, 4'd0, 1'b0);
    chk("F_auto_clr", auto_fired, 0);
    for (int i = 0; i < 7; i++) put(8'd0);
    put(8'd200);
    chk("F_trig", trig_addr, 7);
    chk("F_auto", auto_fired, 0);

    // normal mode, constant 50: never triggers
    do_arm(8'd128, 1'b0, 1'b0, 4'd4, 1'b0);
    for (int i = 0; i < 24; i++) put(8'd50);
    chk("H_busy", busy, 1);
    chk("H_done", done, 0);

    // pre_len = DEPTH-1: done on the trigger sample
    do_arm(8'd128, 1'b0, 1'b0, 4'd15, 1'b0);
    for (int i = 0; i < 15; i++) put(8'(i));
    chk("I_done_early", done, 0);
    put(8'd200);
    chk("I_done", done, 1);
    chk("I_trig", trig_addr, 15);
    chk("I_start", start_addr, 0);
    rd_chk("I_rd15", 4'd15, 8'd200);
    rd_chk("I_rd0", 4'd0, 8'd0);
    rd_chk("I_rd14", 4'd14, 8'd14);

    // synchronous reset mid-capture
    do_arm(8'd128, 1'b0, 1'b1, 4'd4, 1'b0);
    for (int i = 0; i < 12; i++) put(8'd50);
    chk("J_auto_pre", auto_fired, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("J_busy", busy, 0);
    chk("J_done", done, 0);
    chk("J_auto", auto_fired, 0);
    chk("J_start", start_addr, 0);
    chk("J_trig", trig_addr, 0);
    chk("J_rd", rd_data, 0);
    sys_rst = 1'b0;
    put(8'd10);
    chk("J_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
